// File: rtl/gpio_checkpoint_pkg.sv
// Shared definitions for the GPIO checkpoint sequencer: state encoding,
// table entry field positions and default timing constants.
package gpio_checkpoint_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MATCH = 3'd1,
        ST_DELAY = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

    // Entry layout: {expect_hi, drive_lo, delay}
    localparam int unsigned ENTRY_W = 32;
    localparam int unsigned HI_W    = 8;
    localparam int unsigned DLY_W   = 16;
    localparam int unsigned EXP_MSB = 31;
    localparam int unsigned EXP_LSB = 24;
    localparam int unsigned DRV_MSB = 23;
    localparam int unsigned DRV_LSB = 16;
    localparam int unsigned DLY_MSB = 15;
    localparam int unsigned DLY_LSB = 0;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 25000;
    localparam int unsigned DEF_STABLE_CYCLES  = 4;

endpackage

// File: rtl/gpio_checkpoint_table.sv
// Step table: DEPTH x DW register file, one write port, async read port.
// Contents are intentionally not reset.
module gpio_checkpoint_table #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gpio_checkpoint_seq.sv
// GPIO checkpoint sequencer: walks a table of expect/respond/delay steps
// against the firmware status byte and answers on the host lane.
// Optional macro GPIO_SYNC_EN inserts a 2-flop synchronizer on checkbits_hi_i.
module gpio_checkpoint_seq
    import gpio_checkpoint_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned AW             = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tbl_we,
    input  logic [AW-1:0]      tbl_addr,
    input  logic [ENTRY_W-1:0] tbl_wdata,
    input  logic [AW:0]        tbl_len,
    input  logic               start,
    input  logic [HI_W-1:0]    checkbits_hi_i,
    output logic [HI_W-1:0]    checkbits_lo_o,
    output logic               checkbits_lo_oe,
    output logic               busy,
    output logic               pass,
    output logic               fail,
    output logic [AW-1:0]      step
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned LW = AW + 1;

    state_e             state_q;
    logic [AW-1:0]      step_q;
    logic [LW-1:0]      len_q;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [SW-1:0]      stab_q, stab_d;
    logic [DLY_W-1:0]   dly_q;
    logic [HI_W-1:0]    lo_q;
    logic               oe_q, busy_q, pass_q, fail_q;

    logic [ENTRY_W-1:0] entry;
    logic [HI_W-1:0]    hi_cmp;
    logic               tbl_wr_ok, hit, match_done, tmo_done, last_step;
    logic [LW-1:0]      len_eff;

`ifdef GPIO_SYNC_EN
    logic [HI_W-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for the asynchronous pad byte
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= checkbits_hi_i;
            sync2_q <= sync1_q;
        end
    end

    assign hi_cmp = sync2_q;
`else
    assign hi_cmp = checkbits_hi_i;
`endif

    assign tbl_wr_ok = tbl_we && !busy_q && (LW'(tbl_addr) < LW'(DEPTH));

    gpio_checkpoint_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (ENTRY_W)
    ) u_table (
        .clk_i   (clock),
        .we_i    (tbl_wr_ok),
        .waddr_i (tbl_addr),
        .wdata_i (tbl_wdata),
        .raddr_i (step_q),
        .rdata_o (entry)
    );

    // Saturating counter updates and step decisions for the current cycle
    always_comb begin
        tmo_d      = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
        hit        = (hi_cmp == entry[EXP_MSB:EXP_LSB]);
        stab_d     = '0;
        if (hit) begin
            stab_d = (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + SW'(1);
        end
        match_done = hit && (stab_d == SW'(STABLE_CYCLES));
        tmo_done   = (tmo_d == TW'(TIMEOUT_CYCLES));
        last_step  = (LW'(step_q) == len_q - LW'(1));
        len_eff    = (tbl_len > LW'(DEPTH)) ? LW'(DEPTH) : tbl_len;
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            len_q   <= '0;
            tmo_q   <= '0;
            stab_q  <= '0;
            dly_q   <= '0;
            lo_q    <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
                        step_q <= '0;
                        tmo_q  <= '0;
                        stab_q <= '0;
                        if (tbl_len == '0) begin
                            pass_q  <= 1'b1;
                            state_q <= ST_PASS;
                        end else begin
                            len_q   <= len_eff;
                            busy_q  <= 1'b1;
                            state_q <= ST_MATCH;
                        end
                    end
                end
                ST_MATCH: begin
                    if (match_done) begin
                        lo_q    <= entry[DRV_MSB:DRV_LSB];
                        oe_q    <= 1'b1;
                        dly_q   <= entry[DLY_MSB:DLY_LSB];
                        tmo_q   <= '0;
                        stab_q  <= '0;
                        state_q <= ST_DELAY;
                    end else if (tmo_done) begin
                        tmo_q   <= '0;
                        stab_q  <= '0;
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_FAIL;
                    end else begin
                        tmo_q  <= tmo_d;
                        stab_q <= stab_d;
                    end
                end
                ST_DELAY: begin
                    if (dly_q == '0) begin
                        if (last_step) begin
                            pass_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_PASS;
                        end else begin
                            step_q  <= step_q + AW'(1);
                            state_q <= ST_MATCH;
                        end
                    end else begin
                        dly_q <= dly_q - DLY_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign checkbits_lo_o  = lo_q;
    assign checkbits_lo_oe = oe_q;
    assign busy            = busy_q;
    assign pass            = pass_q;
    assign fail            = fail_q;
    assign step            = step_q;

endmodule

// File: tb/tb_gpio_checkpoint_seq.sv
// Bench for gpio_checkpoint_seq: timestamp-based reference model plus
// directed scenarios with literal expectations.
module tb_gpio_checkpoint_seq;

    localparam int TIMEOUT = 100;
    localparam int STABLE  = 4;
`ifdef GPIO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clock, reset, tbl_we, start;
    logic [3:0]  tbl_addr;
    logic [31:0] tbl_wdata;
    logic [4:0]  tbl_len;
    logic [7:0]  hi, lo;
    logic        oe, busy, pass, fail;
    logic [3:0]  step;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    gpio_checkpoint_seq #(
        .DEPTH(16), .AW(4), .TIMEOUT_CYCLES(TIMEOUT), .STABLE_CYCLES(STABLE)
    ) dut (
        .clock(clock), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_len(tbl_len), .start(start),
        .checkbits_hi_i(hi), .checkbits_lo_o(lo), .checkbits_lo_oe(oe),
        .busy(busy), .pass(pass), .fail(fail), .step(step)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] prog   [6] = '{32'hA0F0_0000, 32'h0B0F_0000, 32'hAB00_03E8,
                                32'h0101_03E8, 32'h0203_0000, 32'h0400_0000};
    logic [7:0]  exp_hi [6] = '{8'hA0, 8'h0B, 8'hAB, 8'h01, 8'h02, 8'h04};
    logic [7:0]  drv_lo [6] = '{8'hF0, 8'h0F, 8'h00, 8'h01, 8'h03, 8'h00};

    // Reference model: phase 0 idle/done, 1 waiting for match, 2 delaying
    int          cyc = 0;
    int          m_phase, m_enter, m_release;
    logic [7:0]  m_lo;
    logic        m_oe, m_busy, m_pass, m_fail;
    logic [3:0]  m_step;
    logic [4:0]  m_len;
    logic [31:0] mtab [16];
    logic [31:0] ent;
    logic [7:0]  eff;
    logic [7:0]  pipe [$];
    logic [7:0]  win  [$];
    bit          all_eq;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_phase = 0; m_lo = 8'h00; m_oe = 0; m_busy = 0; m_pass = 0; m_fail = 0;
            m_step = 4'd0; m_len = 5'd0; m_enter = 0; m_release = 0;
            pipe.delete();
            for (int k = 0; k < LAT; k++) pipe.push_back(8'h00);
            win.delete();
        end else begin
            if (LAT == 0) eff = hi;
            else begin
                pipe.push_back(hi);
                eff = pipe.pop_front();
            end
            win.push_back(eff);
            if (win.size() > STABLE) void'(win.pop_front());
            if (tbl_we && !m_busy) mtab[tbl_addr] = tbl_wdata;
            case (m_phase)
                0: if (start) begin
                    m_pass = 0; m_fail = 0; m_step = 4'd0;
                    if (tbl_len == 5'd0) m_pass = 1;
                    else begin
                        m_len = tbl_len; m_busy = 1; m_phase = 1; m_enter = cyc;
                    end
                end
                1: begin
                    ent = mtab[m_step];
                    all_eq = (win.size() == STABLE);
                    foreach (win[k]) if (win[k] != ent[31:24]) all_eq = 0;
                    if (all_eq && (cyc - m_enter >= STABLE)) begin
                        m_lo = ent[23:16]; m_oe = 1;
                        m_release = cyc + int'(ent[15:0]) + 1;
                        m_phase = 2;
                    end else if (cyc - m_enter == TIMEOUT) begin
                        m_fail = 1; m_busy = 0; m_phase = 0;
                    end
                end
                2: if (cyc == m_release) begin
                    if (int'(m_step) == int'(m_len) - 1) begin
                        m_pass = 1; m_busy = 0; m_phase = 0;
                    end else begin
                        m_step = m_step + 4'd1; m_enter = cyc; m_phase = 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        if (armed) begin
            total++;
            if ({lo, oe, busy, pass, fail, step} !== {m_lo, m_oe, m_busy, m_pass, m_fail, m_step}) begin
                bad++;
                $display("FAIL cycle_compare @%0d: got lo=%h oe=%b busy=%b pass=%b fail=%b step=%0d, want lo=%h oe=%b busy=%b pass=%b fail=%b step=%0d",
                         cyc, lo, oe, busy, pass, fail, step, m_lo, m_oe, m_busy, m_pass, m_fail, m_step);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_for(input logic [3:0] s, input logic [7:0] v, input string name);
        bit seen = 0;
        for (int k = 0; k < 1500; k++) begin
            if (oe === 1'b1 && step === s && lo === v) begin
                seen = 1;
                break;
            end
            tick(1);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: drive %h on step %0d not seen, last lo=%h step=%0d", name, v, s, lo, step);
        end
    endtask

    task automatic run_steps(input int first);
        for (int i = first; i < 6; i++) begin
            hi = exp_hi[i];
            wait_for(4'(i), drv_lo[i], "step_drive");
        end
    endtask

    task automatic kick(input logic [4:0] len);
        tbl_len = len;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        tbl_len = '0; start = 1'b0; hi = 8'h00;
        tick(2);
        reset = 1'b0;
        armed = 1;
        check("reset_lo", 32'(lo), 32'h00);
        check("reset_oe", 32'(oe), 32'h0);
        check("reset_flags", 32'({busy, pass, fail}), 32'h0);
        check("reset_step", 32'(step), 32'h0);

        for (int i = 0; i < 6; i++) begin
            tbl_we = 1'b1; tbl_addr = 4'(i); tbl_wdata = prog[i];
            tick(1);
        end
        tbl_we = 1'b0;

        // Bring-up sequence
        hi = 8'hA0;
        kick(5'd6);
        check("run1_busy", 32'(busy), 32'h1);
        tick(3 + LAT);
        check("run1_no_early_drive", 32'(oe), 32'h0);
        tick(1);
        check("run1_first_drive", 32'({oe, lo}), 32'h1F0);
        run_steps(1);
        tick(2);
        check("run1_pass", 32'({pass, fail, busy}), 32'h4);
        check("run1_last_step", 32'(step), 32'h5);

        // Busy guards and restart from PASS
        hi = 8'h00;
        kick(5'd6);
        check("restart_pass_cleared", 32'({pass, busy}), 32'h1);
        check("restart_keeps_lo", 32'({oe, lo}), 32'h100);
        tbl_we = 1'b1; tbl_addr = 4'd0; tbl_wdata = 32'h5555_0000; start = 1'b1;
        tick(1);
        tbl_we = 1'b0; start = 1'b0;
        check("start_while_busy", 32'({busy, step}), 32'h10);
        hi = 8'hA0;
        wait_for(4'd0, 8'hF0, "write_while_busy_dropped");
        run_steps(1);
        tick(2);
        check("run2_pass", 32'(pass), 32'h1);

        // Glitch rejection
        hi = 8'h00;
        kick(5'd6);
        hi = 8'hA0; tick(3);
        hi = 8'h00; tick(1);
        hi = 8'hA0; tick(3 + LAT);
        check("glitch_no_drive", 32'(lo), 32'h00);
        tick(1);
        check("glitch_drive", 32'(lo), 32'hF0);

        // Reset during a long delay
        hi = 8'h0B; wait_for(4'd1, 8'h0F, "glitch_run_step1");
        hi = 8'hAB; wait_for(4'd2, 8'h00, "glitch_run_step2");
        tick(10);
        check("delay_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        tick(1);
        check("midreset_outputs", 32'({oe, lo, busy, pass, fail, step}), 32'h0);
        reset = 1'b0;

        // Timeout
        hi = 8'h00;
        kick(5'd6);
        tick(TIMEOUT - 1);
        check("timeout_not_yet", 32'(fail), 32'h0);
        tick(1);
        check("timeout_fail", 32'({fail, pass, busy, oe}), 32'h8);
        check("timeout_step", 32'(step), 32'h0);

        // Empty table
        kick(5'd0);
        check("len0_pass", 32'({pass, fail, busy, oe}), 32'h8);
        tick(5);

        armed = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
